// File: rtl/jpeg_dec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_dec_pkg
//  Description : Shared constants and types for the JPEG decoder datapath:
//                coefficient width, block size and the zigzag scan table.
//  Revision    : 1.0 - initial release
// ============================================================================
package jpeg_dec_pkg;

    localparam int COEF_W   = 12;
    localparam int BLK_SIZE = 64;

    // ZZ[k] is the raster address {row,col} of the k-th coefficient in scan order
    localparam logic [5:0] ZZ [BLK_SIZE] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef logic signed [COEF_W-1:0] coef_t;

endpackage
`default_nettype wire

// File: rtl/dezigzag_bank.sv
`default_nettype none
// ============================================================================
//  Module      : dezigzag_bank
//  Description : 64-entry coefficient store, one synchronous write port and
//                one registered read port. Storage itself is not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dezigzag_bank
    import jpeg_dec_pkg::*;
#(
    parameter int DATA_W = COEF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [5:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [5:0]        raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [BLK_SIZE];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // The read register doubles as the output data register, so it holds when re_i is low
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dezigzag_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : dezigzag_buffer
//  Description : Ping-pong reorder buffer, zigzag-order input to raster-order
//                output. Define DEZIGZAG_TRANSPOSE_EN for column-major reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module dezigzag_buffer
    import jpeg_dec_pkg::*;
#(
    parameter int DATA_W = COEF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [5:0]        out_idx,
    output logic              out_last
);

    logic [1:0] full_q,      full_d;
    logic       wr_bank_q,   wr_bank_d;
    logic       rd_bank_q,   rd_bank_d;
    logic [5:0] wr_cnt_q,    wr_cnt_d;
    logic [5:0] rd_cnt_q,    rd_cnt_d;
    logic       in_ready_q,  in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic [5:0] out_idx_q,   out_idx_d;
    logic       out_last_q,  out_last_d;
    logic       out_bank_q,  out_bank_d;

    logic              wr_en;
    logic              rd_en;
    logic [5:0]        raddr;
    logic [DATA_W-1:0] rdata [2];

`ifdef DEZIGZAG_TRANSPOSE_EN
    assign raddr = {rd_cnt_q[2:0], rd_cnt_q[5:3]};
`else
    assign raddr = rd_cnt_q;
`endif

    assign wr_en = in_valid && in_ready_q;
    assign rd_en = full_q[rd_bank_q] && (!out_valid_q || out_ready);

    always_comb begin
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_bank_d  = out_bank_q;

        if (wr_en) begin
            wr_cnt_d = wr_cnt_q + 6'd1;
            if (wr_cnt_q == 6'd63) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end

        if (rd_en) begin
            rd_cnt_d    = rd_cnt_q + 6'd1;
            out_valid_d = 1'b1;
            out_idx_d   = raddr;
            out_last_d  = (raddr == 6'd63);
            out_bank_d  = rd_bank_q;
            if (rd_cnt_q == 6'd63) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Registered so in_ready never depends combinationally on out_ready
        in_ready_d = !full_d[wr_bank_d];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q      <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= 6'd0;
            rd_cnt_q    <= 6'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= 6'd0;
            out_last_q  <= 1'b0;
            out_bank_q  <= 1'b0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_bank_q  <= out_bank_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dezigzag_bank #(
            .DATA_W (DATA_W)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .we_i    (wr_en && (wr_bank_q == 1'(b))),
            .waddr_i (ZZ[wr_cnt_q]),
            .wdata_i (in_data),
            .re_i    (rd_en && (rd_bank_q == 1'(b))),
            .raddr_i (raddr),
            .rdata_o (rdata[b])
        );
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = rdata[out_bank_q];
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: doc/dezigzag_buffer.md
Name: dezigzag_buffer

Overview:
Decoder-side counterpart of the encoder's zigzag stage. It accepts quantized DCT coefficients in zigzag scan order, 64 per 8x8 block, and emits them in raster (row-major) order toward the IDCT MAC units. It is a double-buffered (ping-pong) reorder store, so one block can be written while the previous block is read.

Parameters:
DATA_W, 12, coefficient width in bits (two's complement, passed through unchanged)

Ports:
clk  in  1  single clock; all logic rising-edge
rst  in  1  synchronous, active-low reset (asserted when 0, sampled on clk)
in_valid  in  1  in_data holds a valid coefficient
in_ready  out  1  buffer can accept in_data this cycle
in_data  in  DATA_W  coefficient, zigzag order
out_valid  out  1  out_data/out_idx are valid
out_ready  in  1  downstream accepts the output this cycle
out_data  out  DATA_W  coefficient, raster order
out_idx  out  6  raster position {row[2:0],col[2:0]} of out_data
out_last  out  1  high with out_idx==63 (last coefficient of the block)

Behaviour:
- Handshakes are valid/ready; a transfer occurs when both are high on a clk edge.
- Storage: two banks of 64 x DATA_W. Bank status bits full[1:0]. wr_bank and rd_bank are 1-bit pointers; wr_cnt and rd_cnt are 6-bit counters.
- Write side: in_ready = !full[wr_bank].
  - The k-th accepted coefficient (k = wr_cnt) is written at raster address ZZ[k], where ZZ is the standard JPEG zigzag table (0,1,8,16,9,2,3,10,17,24,...,63).
  - wr_cnt increments on every transfer and wraps 63->0. At that wrap, full[wr_bank] is set and wr_bank toggles.
- Read side is a two-stage pipeline:
  - Read-address stage: a read is issued from address rd_cnt of rd_bank when full[rd_bank]==1 and the output register is empty or being drained this cycle.
  - Output register: holds out_data, out_idx, out_last and out_valid.
  - After the read at rd_cnt==63 is issued, full[rd_bank] clears and rd_bank toggles.
- Output hold: while out_valid && !out_ready, out_data, out_idx and out_last are stable and no new read is issued.
- Latency and throughput:
  - Final input write at edge t sets full at t. The first output of that block is valid after edge t+1 (one-cycle registered read).
  - Steady state, with out_ready held high and input never stalled, is one coefficient per cycle on each side with no bubbles between blocks.
- Simultaneous events:
  - Write completion on one bank and read completion on the other in the same cycle are both honoured.
  - If the read side frees the bank that wr_bank points to in the same cycle, in_ready still reflects the registered full bit. It rises one cycle later; no combinational path from read to in_ready.
- Full condition: both banks full -> in_ready=0 until a bank drains.
- Empty condition: both banks empty -> out_valid=0 once the output register drains.
- Reset (rst==0), including mid-block:
  - full=0, wr_bank=rd_bank=0, wr_cnt=rd_cnt=0.
  - out_valid=0, out_last=0, out_idx=0, out_data=0.
  - in_ready is 0 during reset and 1 from the first cycle after release.
  - Partial blocks are discarded. Memory contents are not reset.
- No combinational path from in_valid to out_* or from out_ready to in_ready.

Optional Feature:
Macro DEZIGZAG_TRANSPOSE_EN.
- Defined: read order is column-major. Read address = {rd_cnt[2:0], rd_cnt[5:3]}. out_idx reports the raster address actually read, and out_last is high when out_idx==63. This feeds the IDCT column pass directly.
- Undefined: read address = rd_cnt (row-major). Gate count and timing are unchanged apart from the address mux.

Decomposition:
- Package jpeg_dec_pkg holds:
  - COEF_W default (12)
  - BLK_SIZE = 64
  - the 64-entry ZZ lookup constant array (6-bit entries)
  - a typedef coef_t (logic signed [COEF_W-1:0])
- Sub-module dezigzag_bank: 64 x DATA_W register file with one synchronous write port and one registered read port. It is instantiated twice; the top holds the control and the pointers.

Test Plan:
1. Single block, in_data=k for k=0..63, out_ready=1 -> out_idx 0..63 with out_data 0,1,5,6,14,15,27,28, then at idx8=2, idx9=4, idx16=3, idx63=63; out_last only at idx 63.
2. Four back-to-back blocks with in_valid and out_ready held 1 -> no in_ready deassertion after the first fill; 256 outputs, one per cycle, with no gaps after the first block's latency.
3. out_ready=0 for 200 cycles while 3 blocks are offered -> in_ready drops after 128 accepts; out_data frozen at idx 0. Releasing out_ready drains all 192 coefficients in order, with nothing lost or duplicated.
4. rst=0 after 30 coefficients of a block, held 1 cycle -> out_valid=0 and in_ready=1 on the next cycle; a fresh 64-coefficient block then outputs correctly, and the stale 30 never appear.
5. Random in_valid and out_ready (50% each), 20 blocks of signed extreme values (-2048, 2047) -> scoreboard matches the inverse-zigzag model; out_* stable whenever stalled.
6. With DEZIGZAG_TRANSPOSE_EN defined, the block from scenario 1 -> out_idx sequence 0,8,16,...,56,1,9,...,63; out_data at idx8=2, idx16=3; out_last at the 64th output (idx 63).
